// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - dmem_bus address map, register offsets and CTRL layout
package dmem_pkg;

  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  // MMIO word offsets, i.e. ALUResult[4:2]
  localparam logic [2:0] OFF_GPIO   = 3'd0;
  localparam logic [2:0] OFF_CYCLE  = 3'd1;
  localparam logic [2:0] OFF_CMP    = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_RELOAD_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT  = 2;
  localparam int STATUS_MATCH_BIT = 0;

  typedef struct packed {
    logic irq_en;
    logic reload;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - compare timer (CYCLE/CMP/STATUS/CTRL), built only with DMEM_TIMER_EN
module mmio_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  off,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  logic [31:0] cycle_q;
  logic [31:0] cmp_q;
  logic        match_q;
  ctrl_t       ctrl_q;
  logic        hit_now;

  // compare uses the pre-update count of this cycle
  assign hit_now = ctrl_q.en && (cycle_q == cmp_q);

  // counter: software load beats reload, reload beats increment
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
    end else if (wr_en && off == OFF_CYCLE) begin
      cycle_q <= wr_data;
    end else if (hit_now && ctrl_q.reload) begin
      cycle_q <= '0;
    end else if (ctrl_q.en) begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  // compare value and control register writes
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q  <= '0;
      ctrl_q <= '0;
    end else if (wr_en) begin
      if (off == OFF_CMP) begin
        cmp_q <= wr_data;
      end
      if (off == OFF_CTRL) begin
        ctrl_q.en     <= wr_data[CTRL_EN_BIT];
        ctrl_q.reload <= wr_data[CTRL_RELOAD_BIT];
        ctrl_q.irq_en <= wr_data[CTRL_IRQ_EN_BIT];
      end
    end
  end

  // sticky MATCH: a new match wins over a same-cycle write-1-to-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
    end else if (hit_now) begin
      match_q <= 1'b1;
    end else if (wr_en && off == OFF_STATUS && wr_data[STATUS_MATCH_BIT]) begin
      match_q <= 1'b0;
    end
  end

  assign irq = match_q & ctrl_q.irq_en;

  // register readback for the timer offsets; everything else reads 0
  always_comb begin
    rd_data = '0;
    case (off)
      OFF_CYCLE:  rd_data = cycle_q;
      OFF_CMP:    rd_data = cmp_q;
      OFF_STATUS: rd_data[STATUS_MATCH_BIT] = match_q;
      OFF_CTRL:   rd_data[2:0] = ctrl_q;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_bus.sv
// rtl/dmem_bus.sv - data RAM + MMIO slave for the CPU M stage; timer under DMEM_TIMER_EN
module dmem_bus
  import dmem_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic          ram_hit;
  logic          mmio_hit;
  logic          mmio_wr;
  logic [AW-1:0] ram_idx;
  logic [2:0]    off;
  logic [7:0]    gpio_q;
  logic [31:0]   timer_rd;
  logic          unused_byte_lane;

  assign ram_hit  = ALUResult[31:AW+2] == DATA_BASE[31:AW+2];
  assign ram_idx  = ALUResult[AW+1:2];
  assign mmio_hit = ALUResult[31:5] == MMIO_BASE[31:5];
  assign off      = ALUResult[4:2];
  assign mmio_wr  = MemWrite && mmio_hit;

  // word-only bus: byte lane bits carry no meaning
  assign unused_byte_lane = ^ALUResult[1:0];

  // RAM store; reset only blocks writes, contents are kept
  always_ff @(posedge clk) begin
    if (!rst && MemWrite && ram_hit) begin
      mem[ram_idx] <= WriteData;
    end
  end

  // GPIO output register
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q <= '0;
    end else if (mmio_wr && off == OFF_GPIO) begin
      gpio_q <= WriteData[7:0];
    end
  end

  assign gpio_out = gpio_q;

`ifdef DMEM_TIMER_EN
  mmio_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mmio_wr),
    .off     (off),
    .wr_data (WriteData),
    .rd_data (timer_rd),
    .irq     (timer_irq)
  );
`else
  assign timer_rd  = '0;
  assign timer_irq = 1'b0;
`endif

  // zero-latency read mux; MMIO reads as 0 while reset is held
  always_comb begin
    ReadData = '0;
    if (ram_hit) begin
      ReadData = mem[ram_idx];
    end else if (mmio_hit && !rst) begin
      if (off == OFF_GPIO) begin
        ReadData = {24'b0, gpio_q};
      end else begin
        ReadData = timer_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus.sv
// tb/tb_dmem_bus.sv - self-checking bench for dmem_bus with a reference model
module tb_dmem_bus;

  localparam int DEPTH = 1024;
  localparam logic [31:0] RB = 32'h1001_0000;
  localparam logic [31:0] MB = 32'hFFFF_0000;
`ifdef DMEM_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] ReadData;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int n_cmp;
  int n_bad;
  bit chk_en;

  // reference model state
  logic [31:0] m_ram [int];
  logic [7:0]  m_gpio;
  logic [31:0] m_cycle;
  logic [31:0] m_cmp;
  logic        m_match;
  logic        m_en;
  logic        m_reload;
  logic        m_irqen;

  dmem_bus #(.DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk       (clk),
    .rst       (rst),
    .MemWrite  (we),
    .ALUResult (addr),
    .WriteData (wd),
    .ReadData  (ReadData),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_ram(input logic [31:0] a);
    return (a >= RB) && (a < RB + 32'(4 * DEPTH));
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return (a >= MB) && (a <= MB + 32'h1F);
  endfunction

  // expected load value; v=0 when the RAM word was never written by the bench
  function automatic void exp_read(input logic [31:0] a, output bit v, output logic [31:0] e);
    int idx;
    v = 1'b1;
    e = '0;
    if (in_ram(a)) begin
      idx = int'((a - RB) / 4);
      if (m_ram.exists(idx)) e = m_ram[idx];
      else v = 1'b0;
    end else if (in_mmio(a) && !rst) begin
      case ((a - MB) / 4)
        0: e = {24'b0, m_gpio};
        1: e = TEN ? m_cycle : 32'h0;
        2: e = TEN ? m_cmp : 32'h0;
        3: e = TEN ? {31'b0, m_match} : 32'h0;
        4: e = TEN ? {29'b0, m_irqen, m_reload, m_en} : 32'h0;
        default: e = '0;
      endcase
    end
  endfunction

  // model update at the clock edge, from the values presented during the cycle
  always @(posedge clk) begin
    int  o;
    bit  hit;
    bit  wr;
    if (rst) begin
      m_gpio = 0; m_cycle = 0; m_cmp = 0; m_match = 0;
      m_en = 0; m_reload = 0; m_irqen = 0;
    end else begin
      o   = int'((addr - MB) / 4);
      wr  = we && in_mmio(addr);
      hit = TEN && m_en && (m_cycle == m_cmp);
      if (wr && o == 0) m_gpio = wd[7:0];
      if (TEN) begin
        if (wr && o == 1) m_cycle = wd;
        else if (hit && m_reload) m_cycle = 0;
        else if (m_en) m_cycle = m_cycle + 1;
        if (hit) m_match = 1;
        else if (wr && o == 3 && wd[0]) m_match = 0;
        if (wr && o == 2) m_cmp = wd;
        if (wr && o == 4) begin
          m_en = wd[0]; m_reload = wd[1]; m_irqen = wd[2];
        end
      end
      if (we && in_ram(addr)) m_ram[int'((addr - RB) / 4)] = wd;
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    bit          v;
    logic [31:0] e;
    if (chk_en) begin
      exp_read(addr, v, e);
      if (v) chk("model_rdata", ReadData, e);
      chk("model_gpio", {24'b0, gpio_out}, {24'b0, m_gpio});
      chk("model_irq", {31'b0, timer_irq}, {31'b0, m_match & m_irqen});
    end
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = r; we = w; addr = a; wd = d;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 0;
    rst = 1; we = 0; addr = 0; wd = 0;
    m_gpio = 0; m_cycle = 0; m_cmp = 0; m_match = 0;
    m_en = 0; m_reload = 0; m_irqen = 0;
    @(posedge clk); #1;
    chk_en = 1;

    // reset state
    drive(1, 0, MB, 0); #3;
    chk("rst_mmio_read", ReadData, 32'h0);
    chk("rst_gpio", {24'b0, gpio_out}, 32'h0);
    chk("rst_irq", {31'b0, timer_irq}, 32'h0);

    // RAM write then read-back; same-cycle read sees the old value
    drive(0, 1, 32'h1001_0008, 32'h1111_1111);
    drive(0, 1, 32'h1001_0008, 32'hDEAD_BEEF); #3;
    chk("ram_old_during_write", ReadData, 32'h1111_1111);
    drive(0, 0, 32'h1001_0008, 0); #3;
    chk("ram_readback", ReadData, 32'hDEAD_BEEF);
    drive(0, 0, 32'h1001_000B, 0); #3;
    chk("ram_low_bits_ignored", ReadData, 32'hDEAD_BEEF);

    // GPIO, then reset overriding a write and blocking a RAM store
    drive(0, 1, MB, 32'h1A5);
    drive(0, 0, MB, 0); #3;
    chk("gpio_out", {24'b0, gpio_out}, 32'hA5);
    chk("gpio_read", ReadData, 32'h0000_00A5);
    drive(1, 1, MB, 32'h3C);
    drive(1, 1, 32'h1001_0008, 32'h0); #3;
    chk("gpio_after_rst", {24'b0, gpio_out}, 32'h0);
    drive(0, 0, 32'h1001_0008, 0); #3;
    chk("ram_write_blocked_in_rst", ReadData, 32'hDEAD_BEEF);

    // unmapped and boundary addresses
    drive(0, 0, 32'h2000_0000, 0); #3;
    chk("unmapped_read", ReadData, 32'h0);
    drive(0, 1, 32'h1001_0FFC, 32'hCAFE_F00D);
    drive(0, 0, 32'h1001_0FFC, 0); #3;
    chk("ram_last_word", ReadData, 32'hCAFE_F00D);
    drive(0, 1, 32'h1001_1000, 32'h1234_5678);
    drive(0, 0, 32'h1001_1000, 0); #3;
    chk("past_ram_end", ReadData, 32'h0);
    drive(0, 1, MB + 32'h14, 32'hFFFF_FFFF);
    drive(0, 0, MB + 32'h14, 0); #3;
    chk("mmio_unmapped_off", ReadData, 32'h0);

`ifdef DMEM_TIMER_EN
    // compare with IRQ: CMP=10, CTRL=EN|IRQ_EN
    drive(0, 1, MB + 32'h08, 32'd10);
    drive(0, 1, MB + 32'h10, 32'b101);
    for (int i = 0; i <= 10; i++) begin
      drive(0, 0, MB + 32'h04, 0); #3;
      chk("cycle_count", ReadData, 32'(i));
      chk("irq_before_match", {31'b0, timer_irq}, 32'h0);
    end
    drive(0, 0, MB + 32'h04, 0); #3;
    chk("cycle_after_match", ReadData, 32'd11);
    chk("irq_after_match", {31'b0, timer_irq}, 32'h1);
    drive(0, 1, MB + 32'h0C, 32'h1); #3;
    chk("irq_during_w1c", {31'b0, timer_irq}, 32'h1);
    drive(0, 0, MB + 32'h0C, 0); #3;
    chk("status_cleared", ReadData, 32'h0);
    chk("irq_cleared", {31'b0, timer_irq}, 32'h0);

    // reload: CMP=3, CTRL=EN|RELOAD
    drive(0, 1, MB + 32'h10, 32'h0);
    drive(0, 1, MB + 32'h04, 32'h0);
    drive(0, 1, MB + 32'h0C, 32'h1);
    drive(0, 1, MB + 32'h08, 32'd3);
    drive(0, 1, MB + 32'h10, 32'b011);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, MB + 32'h04, 0); #3;
      chk("reload_seq", ReadData, 32'(i % 4));
    end
    drive(0, 0, MB + 32'h0C, 0); #3;
    chk("reload_match", ReadData, 32'h1);
    chk("reload_no_irq", {31'b0, timer_irq}, 32'h0);

    // W1C on the exact match cycle: set wins
    drive(0, 1, MB + 32'h10, 32'h0);
    drive(0, 1, MB + 32'h04, 32'h0);
    drive(0, 1, MB + 32'h0C, 32'h1);
    drive(0, 1, MB + 32'h08, 32'd2);
    drive(0, 0, MB + 32'h0C, 0); #3;
    chk("status_clear_pre", ReadData, 32'h0);
    drive(0, 1, MB + 32'h10, 32'b111);
    drive(0, 0, MB + 32'h04, 0); #3;
    chk("race_cycle0", ReadData, 32'd0);
    drive(0, 0, MB + 32'h04, 0); #3;
    chk("race_cycle1", ReadData, 32'd1);
    drive(0, 1, MB + 32'h0C, 32'h1); #3;
    chk("race_status_old", ReadData, 32'h0);
    drive(0, 0, MB + 32'h0C, 0); #3;
    chk("race_set_wins", ReadData, 32'h1);
    chk("race_irq", {31'b0, timer_irq}, 32'h1);

    // wrap: load 0xFFFFFFFE while running
    drive(0, 1, MB + 32'h08, 32'd5);
    drive(0, 1, MB + 32'h10, 32'b001);
    drive(0, 1, MB + 32'h04, 32'hFFFF_FFFE);
    drive(0, 0, MB + 32'h04, 0); #3;
    chk("wrap_fffffffe", ReadData, 32'hFFFF_FFFE);
    drive(0, 0, MB + 32'h04, 0); #3;
    chk("wrap_ffffffff", ReadData, 32'hFFFF_FFFF);
    drive(0, 0, MB + 32'h04, 0); #3;
    chk("wrap_zero", ReadData, 32'h0);

    // reset mid-operation beats a concurrent CTRL write
    drive(1, 1, MB + 32'h10, 32'b111);
    drive(0, 0, MB + 32'h10, 0); #3;
    chk("rst_ctrl", ReadData, 32'h0);
    chk("rst_irq_mid", {31'b0, timer_irq}, 32'h0);
    drive(0, 0, MB + 32'h04, 0); #3;
    chk("rst_cycle", ReadData, 32'h0);
`else
    // timer offsets absent: writes ignored, reads 0
    drive(0, 1, MB + 32'h10, 32'b111);
    drive(0, 1, MB + 32'h04, 32'd5);
    drive(0, 0, MB + 32'h10, 0); #3;
    chk("no_timer_ctrl", ReadData, 32'h0);
    chk("no_timer_irq", {31'b0, timer_irq}, 32'h0);
    drive(0, 0, MB + 32'h04, 0); #3;
    chk("no_timer_cycle", ReadData, 32'h0);
`endif

    drive(0, 0, 32'h0, 0);
    @(posedge clk); #1;
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
